updown_counter: RTL and testbench
=================================

UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits (WIDTH >= 2).
REQ-002 Parameter STEP_W, default 4, step input width in bits (1 <= STEP_W <= WIDTH).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 clear  input  1  synchronous clear of count and flags; no reset of limit or mode.
REQ-006 x  input  WIDTH  load value.
REQ-007 load_x  input  1  valid bit qualifying x.
REQ-008 en  input  1  enables one count step per cycle.
REQ-009 up  input  1  direction: 1 counts up, 0 counts down.
REQ-010 step  input  STEP_W  unsigned step magnitude; 0 is legal and means hold.
REQ-011 limit  input  WIDTH  inclusive upper bound; legal count range is 0..limit.
REQ-012 mode  input  cnt_mode_t  boundary behaviour: WRAP, SATURATE or ONESHOT.
REQ-013 y  output  WIDTH  registered count value.
REQ-014 tc  output  1  registered terminal-count pulse, high for one cycle per boundary event.
REQ-015 done  output  1  registered; high while a ONESHOT run has terminated.

Function
REQ-016 Command priority per cycle SHALL be reset > clear > load_x > en; with none asserted, y holds and tc is 0.
REQ-017 clear SHALL set y=0, tc=0, done=0 on the next edge.
REQ-018 load_x SHALL set y=min(x, limit), tc=0, done=0 on the next edge, regardless of en.
REQ-019 en with done=0 SHALL compute the candidate in WIDTH+1 bits: up: y+step; down: y-step (borrow detected).
REQ-020 A boundary event SHALL occur when up and candidate > limit, or when down and the candidate underflows below 0.
REQ-021 No boundary event: y SHALL take the candidate value one cycle after en (latency 1), and tc=0.
REQ-022 WRAP boundary: up SHALL set y=0; down SHALL set y=limit; tc=1 for that cycle.
REQ-023 SATURATE boundary: up SHALL set y=limit; down SHALL set y=0; tc=1 only on the first saturating step; further en at the same rail holds y with tc=0.
REQ-024 ONESHOT boundary: as SATURATE, plus done=1; while done=1, en SHALL be ignored until clear, load_x or reset.
REQ-025 step=0 with en SHALL hold y and never raise tc.
REQ-026 If limit is lowered below the current y, the next up step SHALL be a boundary event; the next down step SHALL compute from y unchanged; y SHALL not change without en, load_x or clear.
REQ-027 limit=0 SHALL hold y at 0; any en with step>0 is a boundary event.
REQ-028 Changing mode or up mid-count SHALL take effect on the next en cycle, with no effect on y until then.
REQ-029 tc SHALL never be high for two consecutive cycles unless consecutive en steps each cross a boundary (WRAP mode).

Reset
REQ-030 reset SHALL force y=0, tc=0, done=0 on the next rising clk, overriding all inputs, including mid-run or while done=1.
REQ-031 There SHALL be no asynchronous reset path; outputs SHALL be deterministic from the first edge with reset high.

Structure
REQ-032 A shared package counter_pkg SHALL hold typedef enum cnt_mode_t {WRAP, SATURATE, ONESHOT} and a default mode constant CNT_MODE_DEFAULT = WRAP.
REQ-033 The datapath SHALL use one sub-module, step_adder (WIDTH+1-bit add/subtract with carry/borrow out), instantiated once; boundary selection and the flag registers live in updown_counter.

Verification (WIDTH=8, STEP_W=4)
REQ-034 WRAP up: limit=9, step=3, y=6 -> en: y=9 tc=0; en: y=0 tc=1; en: y=3 tc=0.
REQ-035 SATURATE down: limit=200, y=5, step=4, up=0 -> en: y=1; en: y=0 tc=1; en: y=0 tc=0.
REQ-036 ONESHOT up: limit=10, y=8, step=2 -> en: y=10 tc=0; en: y=10 tc=1 done=1; en x3: y=10 done=1; load_x with x=4: y=4 done=0.
REQ-037 Priority: clear, load_x (x=77) and en all high with y=50 -> y=0; load_x and en with x=77 -> y=77; load_x with x=250, limit=100 -> y=100.
REQ-038 Reset mid-run: ONESHOT, done=1, y=10, reset with load_x (x=33) -> y=0 tc=0 done=0 next cycle.
REQ-039 Limit lowered: y=50, limit set to 20, WRAP, up, step=1 -> en: y=0 tc=1; down with y=50 instead -> y=49.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the up/down counter: boundary behaviour modes.
package counter_pkg;

  typedef enum logic [1:0] {
    WRAP     = 2'd0,
    SATURATE = 2'd1,
    ONESHOT  = 2'd2
  } cnt_mode_t;

  localparam cnt_mode_t CNT_MODE_DEFAULT = WRAP;

endpackage

// File: rtl/updown_counter_if.sv
// Command/status bundle of the up/down counter.
// Handshake: load_x is the valid bit qualifying x. There is no ready,
// because the counter accepts a load on every edge where it is not
// overridden by reset or clear. All other inputs are level commands
// sampled on the rising clock edge.
interface updown_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);

  logic                   clear;
  logic [WIDTH-1:0]       x;
  logic                   load_x;
  logic                   en;
  logic                   up;
  logic [STEP_W-1:0]      step;
  logic [WIDTH-1:0]       limit;
  counter_pkg::cnt_mode_t mode;
  logic [WIDTH-1:0]       y;
  logic                   tc;
  logic                   done;

  // The master issues commands, the counter (slave) returns status.
  modport master (
    output clear, x, load_x, en, up, step, limit, mode,
    input  y, tc, done
  );

  modport slave (
    input  clear, x, load_x, en, up, step, limit, mode,
    output y, tc, done
  );

endinterface

// File: rtl/updown_counter_step_adder.sv
// N-bit add/subtract; cout is the carry for add and the borrow for subtract.
module step_adder #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] full;

  // Two's-complement subtract: a + ~b + 1, borrow is the inverted carry.
  always_comb begin
    full = {1'b0, a} + {1'b0, b ^ {N{sub}}} + {{N{1'b0}}, sub};
    sum  = full[N-1:0];
    cout = sub ? ~full[N] : full[N];
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with programmable step, inclusive limit and
// wrap / saturate / one-shot boundary behaviour.
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input logic               clk,
  input logic               reset,
  updown_counter_if.slave   bus
);

  logic [WIDTH-1:0] y_q, y_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  // pinned: the previous effective step was a saturating boundary, so a
  // repeated push against the same rail must not pulse tc again.
  logic             pinned_q, pinned_d;

  logic [WIDTH:0]   cand;
  logic             carry_borrow;
  logic             boundary;
  logic [WIDTH-1:0] rail;
  logic [WIDTH-1:0] wrap_val;

  // Candidate is computed one bit wider so overflow past limit and
  // underflow below zero are both visible.
  step_adder #(.N(WIDTH + 1)) u_step_adder (
    .a    ({1'b0, y_q}),
    .b    ({{(WIDTH + 1 - STEP_W){1'b0}}, bus.step}),
    .sub  (~bus.up),
    .sum  (cand),
    .cout (carry_borrow)
  );

  // Boundary detection and the rail/wrap targets for the current direction.
  always_comb begin
    boundary = bus.up ? (cand > {1'b0, bus.limit}) : carry_borrow;
    rail     = bus.up ? bus.limit : '0;
    wrap_val = bus.up ? '0 : bus.limit;
  end

  // Next-state: clear > load_x > en; reset is applied in the register.
  always_comb begin
    y_d      = y_q;
    tc_d     = 1'b0;
    done_d   = done_q;
    pinned_d = pinned_q;
    if (bus.clear) begin
      y_d      = '0;
      done_d   = 1'b0;
      pinned_d = 1'b0;
    end else if (bus.load_x) begin
      y_d      = (bus.x > bus.limit) ? bus.limit : bus.x;
      done_d   = 1'b0;
      pinned_d = 1'b0;
    end else if (bus.en && !done_q && (bus.step != '0)) begin
      if (!boundary) begin
        y_d      = cand[WIDTH-1:0];
        pinned_d = 1'b0;
      end else begin
        case (bus.mode)
          SATURATE, ONESHOT: begin
            y_d      = rail;
            tc_d     = !(pinned_q && (y_q == rail));
            pinned_d = 1'b1;
            if (bus.mode == ONESHOT) done_d = 1'b1;
          end
          default: begin
            y_d      = wrap_val;
            tc_d     = 1'b1;
            pinned_d = 1'b0;
          end
        endcase
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q      <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
      pinned_q <= 1'b0;
    end else begin
      y_q      <= y_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
      pinned_q <= pinned_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.tc   = tc_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: directed vector table, then randomized
// traffic against an arithmetic reference model.
module tb_updown_counter;
  import counter_pkg::*;

  localparam int W = 8;
  localparam int S = 4;

  typedef struct {
    string     name;
    bit        rst, clr, ld, en, up;
    int        step, x, limit;
    cnt_mode_t mode;
    int        ey, etc, edone;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  vec_t vecs[$];
  logic [W+1:0] exp_q[$];

  // Reference model state.
  int m_y = 0;
  int m_tc = 0;
  int m_done = 0;
  bit m_pinned = 1'b0;

  updown_counter_if #(.WIDTH(W), .STEP_W(S)) bus ();

  updown_counter #(.WIDTH(W), .STEP_W(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input string n, input bit rst, clr, ld, en, up,
                              input int step, x, limit, input cnt_mode_t mode,
                              input int ey, etc, ed);
    vec_t v;
    v.name = n; v.rst = rst; v.clr = clr; v.ld = ld; v.en = en; v.up = up;
    v.step = step; v.x = x; v.limit = limit; v.mode = mode;
    v.ey = ey; v.etc = etc; v.edone = ed;
    vecs.push_back(v);
  endfunction

  // Model: boundary rules stated with signed integer arithmetic.
  task automatic model_step(input vec_t v);
    int c;
    int rail;
    if (v.rst || v.clr) begin
      m_y = 0; m_tc = 0; m_done = 0; m_pinned = 0;
    end else if (v.ld) begin
      m_y = (v.x > v.limit) ? v.limit : v.x;
      m_tc = 0; m_done = 0; m_pinned = 0;
    end else if (v.en && m_done == 0 && v.step != 0) begin
      c = v.up ? m_y + v.step : m_y - v.step;
      if ((v.up && c > v.limit) || (!v.up && c < 0)) begin
        if (v.mode == WRAP) begin
          m_y = v.up ? 0 : v.limit;
          m_tc = 1; m_pinned = 0;
        end else begin
          rail = v.up ? v.limit : 0;
          m_tc = (m_pinned && m_y == rail) ? 0 : 1;
          m_y = rail; m_pinned = 1;
          if (v.mode == ONESHOT) m_done = 1;
        end
      end else begin
        m_y = c; m_tc = 0; m_pinned = 0;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model, sample after the edge.
  task automatic drive(input vec_t v);
    reset      = v.rst;
    bus.clear  = v.clr;
    bus.load_x = v.ld;
    bus.en     = v.en;
    bus.up     = v.up;
    bus.step   = S'(v.step);
    bus.x      = W'(v.x);
    bus.limit  = W'(v.limit);
    bus.mode   = v.mode;
    model_step(v);
    exp_q.push_back({1'(m_done), 1'(m_tc), W'(m_y)});
    @(posedge clk);
    #1;
  endtask

  task automatic check_against_model(input string tag);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_y"}, int'(bus.y), int'(e[W-1:0]));
      chk({tag, "_tc"}, int'(bus.tc), int'(e[W]));
      chk({tag, "_done"}, int'(bus.done), int'(e[W+1]));
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    bus.clear = 0; bus.load_x = 0; bus.en = 0; bus.up = 1; bus.step = '0;
    bus.x = '0; bus.limit = '1; bus.mode = CNT_MODE_DEFAULT;

    //            name        rst clr ld en up step x   lim  mode      y   tc d
    add("reset",             1, 0, 0, 0, 1, 0, 0,   255, WRAP,     0,  0, 0);
    add("reset_ld",          1, 0, 1, 1, 1, 3, 99,  255, WRAP,     0,  0, 0);
    // wrap up
    add("wrap_ld6",          0, 0, 1, 0, 1, 3, 6,   9,   WRAP,     6,  0, 0);
    add("wrap_up1",          0, 0, 0, 1, 1, 3, 0,   9,   WRAP,     9,  0, 0);
    add("wrap_up2",          0, 0, 0, 1, 1, 3, 0,   9,   WRAP,     0,  1, 0);
    add("wrap_up3",          0, 0, 0, 1, 1, 3, 0,   9,   WRAP,     3,  0, 0);
    add("idle_hold",         0, 0, 0, 0, 1, 3, 0,   9,   WRAP,     3,  0, 0);
    add("step0_hold",        0, 0, 0, 1, 1, 0, 0,   9,   WRAP,     3,  0, 0);
    // saturate down
    add("sat_ld5",           0, 0, 1, 0, 0, 4, 5,   200, SATURATE, 5,  0, 0);
    add("sat_dn1",           0, 0, 0, 1, 0, 4, 0,   200, SATURATE, 1,  0, 0);
    add("sat_dn2",           0, 0, 0, 1, 0, 4, 0,   200, SATURATE, 0,  1, 0);
    add("sat_dn3",           0, 0, 0, 1, 0, 4, 0,   200, SATURATE, 0,  0, 0);
    // oneshot up
    add("os_ld8",            0, 0, 1, 0, 1, 2, 8,   10,  ONESHOT,  8,  0, 0);
    add("os_up1",            0, 0, 0, 1, 1, 2, 0,   10,  ONESHOT,  10, 0, 0);
    add("os_up2",            0, 0, 0, 1, 1, 2, 0,   10,  ONESHOT,  10, 1, 1);
    add("os_ign1",           0, 0, 0, 1, 1, 2, 0,   10,  ONESHOT,  10, 0, 1);
    add("os_ign2",           0, 0, 0, 1, 0, 2, 0,   10,  ONESHOT,  10, 0, 1);
    add("os_ign3",           0, 0, 0, 1, 1, 2, 0,   10,  WRAP,     10, 0, 1);
    add("os_ld4",            0, 0, 1, 0, 1, 2, 4,   10,  ONESHOT,  4,  0, 0);
    // priority
    add("pri_ld50",          0, 0, 1, 0, 1, 1, 50,  255, WRAP,     50, 0, 0);
    add("pri_clr",           0, 1, 1, 1, 1, 1, 77,  255, WRAP,     0,  0, 0);
    add("pri_ld_en",         0, 0, 1, 1, 1, 1, 77,  255, WRAP,     77, 0, 0);
    add("pri_ld_clip",       0, 0, 1, 0, 1, 1, 250, 100, WRAP,     100,0, 0);
    // reset during a finished oneshot run
    add("rst_ld8",           0, 0, 1, 0, 1, 2, 8,   10,  ONESHOT,  8,  0, 0);
    add("rst_up1",           0, 0, 0, 1, 1, 2, 0,   10,  ONESHOT,  10, 0, 0);
    add("rst_up2",           0, 0, 0, 1, 1, 2, 0,   10,  ONESHOT,  10, 1, 1);
    add("rst_mid",           1, 0, 1, 0, 1, 2, 33,  10,  ONESHOT,  0,  0, 0);
    // limit lowered below y
    add("lim_ld50",          0, 0, 1, 0, 1, 1, 50,  255, WRAP,     50, 0, 0);
    add("lim_hold",          0, 0, 0, 0, 1, 1, 0,   20,  WRAP,     50, 0, 0);
    add("lim_up",            0, 0, 0, 1, 1, 1, 0,   20,  WRAP,     0,  1, 0);
    add("lim_ld50b",         0, 0, 1, 0, 1, 1, 50,  255, WRAP,     50, 0, 0);
    add("lim_dn",            0, 0, 0, 1, 0, 1, 0,   20,  WRAP,     49, 0, 0);
    add("lim_sat_up",        0, 0, 0, 1, 1, 1, 0,   20,  SATURATE, 20, 1, 0);
    // limit zero and back-to-back wrap pulses
    add("lim0_ld",           0, 0, 1, 0, 1, 5, 9,   0,   WRAP,     0,  0, 0);
    add("lim0_up",           0, 0, 0, 1, 1, 5, 0,   0,   WRAP,     0,  1, 0);
    add("lim0_dn",           0, 0, 0, 1, 0, 5, 0,   0,   WRAP,     0,  1, 0);
    add("wrap3_ld",          0, 0, 1, 0, 1, 4, 0,   3,   WRAP,     0,  0, 0);
    add("wrap3_a",           0, 0, 0, 1, 1, 4, 0,   3,   WRAP,     0,  1, 0);
    add("wrap3_b",           0, 0, 0, 1, 1, 4, 0,   3,   WRAP,     0,  1, 0);
    add("wrap_dn",           0, 0, 0, 1, 0, 1, 0,   3,   WRAP,     3,  1, 0);
    add("clr_all",           0, 1, 0, 1, 1, 1, 0,   3,   WRAP,     0,  0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      void'(exp_q.pop_front());
      chk({vecs[i].name, "_y"}, int'(bus.y), vecs[i].ey);
      chk({vecs[i].name, "_tc"}, int'(bus.tc), vecs[i].etc);
      chk({vecs[i].name, "_done"}, int'(bus.done), vecs[i].edone);
    end

    // Randomized traffic against the model.
    v.name = "rand"; v.limit = 255;
    for (int i = 0; i < 3000; i++) begin
      v.rst  = ($urandom_range(0, 63) == 0);
      v.clr  = ($urandom_range(0, 31) == 0);
      v.ld   = ($urandom_range(0, 7) == 0);
      v.en   = ($urandom_range(0, 3) != 0);
      v.up   = ($urandom_range(0, 2) != 0) ^ (i[9]);
      v.step = $urandom_range(0, 15);
      v.x    = $urandom_range(0, 255);
      if ($urandom_range(0, 15) == 0) v.limit = $urandom_range(0, 255);
      if ($urandom_range(0, 31) == 0) v.limit = $urandom_range(0, 3);
      v.mode = cnt_mode_t'($urandom_range(0, 2));
      v.ey = 0; v.etc = 0; v.edone = 0;
      drive(v);
      check_against_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
